// File: rtl/mont_pkg.sv
// Shared Montgomery constants and FSM encoding for the mod 2^255-19 multiplier and inverse blocks.
// Pure declarations: no latency, no flow control.
package mont_pkg;

  localparam int N_BITS_DEF = 255;
  localparam int T_BITS_DEF = N_BITS_DEF + 2;
  localparam int ITER_DEF   = 256;

  // P = 2^255 - 19
  localparam logic [N_BITS_DEF-1:0] P = {{247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOP = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mont_mul_step.sv
// One radix-2 Montgomery iteration: t_next = (t + a_i*b [+ P]) / 2.
// Purely combinational, zero latency, no flow control.
module mont_mul_step
  import mont_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic [N_BITS+1:0] t,
  input  logic              a_i,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS+1:0] t_next
);

  localparam int T_W = N_BITS + 2;
  localparam logic [T_W-1:0] P_EXT = T_W'(P);

  logic [T_W-1:0] sum;
  logic [T_W-1:0] sum_p;

  // With t < 2P and b < P, sum_p stays below 4P < 2^(N_BITS+2).
  always_comb begin
    sum    = t + (a_i ? {2'b00, b} : '0);
    sum_p  = sum[0] ? (sum + P_EXT) : sum;
    t_next = sum_p >> 1;
  end

endmodule

// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiply a*b*2^-ITER mod P; o_finished pulses ITER+2 cycles after start.
// No backpressure: i_start ignored while busy. MONT_FROM_DOMAIN_EN adds i_from_mont (forces B=1).
module montgomery_mul
  import mont_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int ITER   = ITER_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
`ifdef MONT_FROM_DOMAIN_EN
  input  logic              i_from_mont,
`endif
  input  logic [N_BITS-1:0] i_a,
  input  logic [N_BITS-1:0] i_b,
  output logic [N_BITS-1:0] o_result,
  output logic              o_finished,
  output logic              o_busy
);

  localparam int T_W = N_BITS + 2;
  localparam int C_W = $clog2(ITER) + 1;
  localparam logic [T_W-1:0] P_EXT    = T_W'(P);
  localparam logic [C_W-1:0] LAST_CNT = C_W'(ITER - 1);

  state_t            state;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [T_W-1:0]    t_q;
  logic [T_W-1:0]    t_step;
  logic [C_W-1:0]    cnt;
  logic [N_BITS-1:0] b_sel;

`ifdef MONT_FROM_DOMAIN_EN
  assign b_sel = i_from_mont ? N_BITS'(1) : i_b;
`else
  assign b_sel = i_b;
`endif

  mont_mul_step #(
    .N_BITS(N_BITS)
  ) u_step (
    .t      (t_q),
    .a_i    (a_q[0]),
    .b      (b_q),
    .t_next (t_step)
  );

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      t_q        <= '0;
      cnt        <= '0;
      o_result   <= '0;
      o_finished <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            a_q   <= i_a;
            b_q   <= b_sel;
            t_q   <= '0;
            cnt   <= '0;
            state <= ST_LOOP;
          end
        end
        ST_LOOP: begin
          // a is consumed LSB first by shifting the register down.
          t_q <= t_step;
          a_q <= a_q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (t_q >= P_EXT) begin
            t_q <= t_q - P_EXT;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          o_result   <= t_q[N_BITS-1:0];
          o_finished <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
